// File: rtl/dmem_resp_pkg.sv
// Shared constants and types for the data-memory responder.
// Holds the FSM state enum, default geometry/latency and the stall counter width.
package dmem_resp_pkg;

  localparam int unsigned DEF_DEPTH       = 64;
  localparam int unsigned DEF_WAIT_CYCLES = 2;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_merge.sv
// Byte-lane helper (combinational).
// Ports: old_word   - current memory word
//        wdata_byte - byte to insert on a byte store
//        lane       - byte lane, little-endian (0 = bits [7:0])
//        merged_word_c - old_word with the selected lane replaced
//        load_byte_c   - selected lane of old_word, zero-extended
module dmem_lane_merge (
  input  logic [31:0] old_word,
  input  logic [7:0]  wdata_byte,
  input  logic [1:0]  lane,
  output logic [31:0] merged_word_c,
  output logic [31:0] load_byte_c
);

  always_comb begin
    merged_word_c = old_word;
    load_byte_c   = 32'd0;
    case (lane)
      2'd0: begin
        merged_word_c[7:0] = wdata_byte;
        load_byte_c[7:0]   = old_word[7:0];
      end
      2'd1: begin
        merged_word_c[15:8] = wdata_byte;
        load_byte_c[7:0]    = old_word[15:8];
      end
      2'd2: begin
        merged_word_c[23:16] = wdata_byte;
        load_byte_c[7:0]     = old_word[23:16];
      end
      default: begin
        merged_word_c[31:24] = wdata_byte;
        load_byte_c[7:0]     = old_word[31:24];
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed stall, single response.
// Optional macro DMEM_RESP_BYTE_EN enables byte (LDRB/STRB) accesses; without it
// byte requests complete with rsp_err=1.
// Ports: clk, reset (async, active-high)
//        req_valid/req_ready handshake; req_we, req_byte, req_addr, req_wdata
//        rsp_valid/rsp_ready handshake; rsp_rdata, rsp_err
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_WAIT = 2'(ST_WAIT);
  localparam logic [1:0] S_RESP = 2'(ST_RESP);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d, byte_q, byte_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic             rdy_q, rdy_d, vld_q, vld_d, err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [31:0] mem [DEPTH];

  // Access operands: live request when completing straight from IDLE, else latched.
  logic          live_c, acc_we_c, acc_byte_c, access_c;
  logic [31:0]   acc_addr_c, acc_wdata_c, old_word_c, merged_c, load_byte_c;
  logic [31:0]   acc_rdata_c, wr_word_c;
  logic [AW-1:0] idx_c;
  logic          oob_c, misalign_c, byte_err_c, acc_err_c, mem_we_c;

  assign live_c      = (state_q == S_IDLE);
  assign acc_we_c    = live_c ? req_we    : we_q;
  assign acc_byte_c  = live_c ? req_byte  : byte_q;
  assign acc_addr_c  = live_c ? req_addr  : addr_q;
  assign acc_wdata_c = live_c ? req_wdata : wdata_q;

  assign idx_c      = acc_addr_c[AW+1:2];
  assign oob_c      = (acc_addr_c[31:2] >= 30'(DEPTH));
  assign misalign_c = !acc_byte_c && (acc_addr_c[1:0] != 2'd0);
`ifdef DMEM_RESP_BYTE_EN
  assign byte_err_c = 1'b0;
`else
  assign byte_err_c = acc_byte_c;
`endif
  assign acc_err_c  = oob_c | misalign_c | byte_err_c;
  assign old_word_c = oob_c ? 32'd0 : mem[idx_c];

  dmem_lane_merge u_lane (
    .old_word      (old_word_c),
    .wdata_byte    (acc_wdata_c[7:0]),
    .lane          (acc_addr_c[1:0]),
    .merged_word_c (merged_c),
    .load_byte_c   (load_byte_c)
  );

  assign acc_rdata_c = acc_byte_c ? load_byte_c : old_word_c;
  assign wr_word_c   = acc_byte_c ? merged_c : acc_wdata_c;
  // Reset is checked here too so a request seen during reset never writes.
  assign mem_we_c    = access_c && acc_we_c && !acc_err_c && !reset;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    vld_d    = vld_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    access_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && rdy_q) begin
          we_d    = req_we;
          byte_d  = req_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            access_c = 1'b1;
            state_d  = S_RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          access_c = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
          err_d   = 1'b0;
          rdata_d = 32'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (access_c) begin
      vld_d   = 1'b1;
      err_d   = acc_err_c;
      rdata_d = (acc_err_c || acc_we_c) ? 32'd0 : acc_rdata_c;
    end
    rdy_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_c] <= wr_word_c;
  end

  assign req_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;

endmodule
